// File: rtl/upuart_tx_if.sv
// TX FIFO read port between a show-ahead FIFO and the UART transmitter.
// Latency: none, plain wires.
// Backpressure: the consumer pops with a one-cycle fifo_rd strobe only when fifo_empty is low.
//
// Signals:
//   fifo_data  - head word of the FIFO, valid whenever fifo_empty is low
//   fifo_empty - FIFO has no word to offer
//   fifo_rd    - one-cycle pop strobe from the consumer
// Modports: master = the consumer (UART), slave = the FIFO.
interface upuart_tx_if;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd
    );
endinterface

// File: rtl/upuart_tx.sv
// 8-bit UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Latency: start bit on txd the cycle after the fifo_rd pop; each bit lasts divisor+1 clocks.
// Backpressure: pops only when enable=1 and the FIFO is non-empty; frames in flight always complete.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   enable            - permits starting new frames (never aborts a running one)
//   divisor           - bit period minus one, in clocks
//   parity_en         - append a parity bit after the data bits
//   parity_odd        - 1 = odd parity, 0 = even parity
//   stop2             - 1 = two stop bits, 0 = one stop bit
//   fifo              - TX FIFO read port (show-ahead data, empty flag, pop strobe)
//   txd               - serial line, idle high
//   busy              - high while a frame is on the line
module upuart_tx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    upuart_tx_if.master          fifo,
    output logic                 txd,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    logic [DIV_WIDTH-1:0] div_q;        // divisor frozen for the current frame
    logic [DIV_WIDTH-1:0] cnt_q;        // clocks left in the current bit, minus one
    logic [7:0]           shift_q;      // data byte, shifted right as bits go out
    logic [2:0]           bit_idx_q;
    logic                 par_en_q;
    logic                 par_bit_q;    // parity bit, precomputed at capture
    logic                 stop2_q;
    logic                 stop_left_q;  // a second stop bit still follows the current one
    logic                 txd_q;
    logic                 busy_q;

    logic                 bit_end;
    logic                 last_stop;
    logic                 pop_d;

    assign bit_end   = (cnt_q == '0);
    assign last_stop = (state_q == STOP) && bit_end && !stop_left_q;

    // The pop strobe has to react to fifo_empty in the same cycle it is
    // asserted, so it is decoded from registered state rather than registered
    // itself. The reset term keeps the FIFO untouched while rst is high.
    assign pop_d = !rst && enable && !fifo.fifo_empty &&
                   ((state_q == IDLE) || last_stop);

    assign fifo.fifo_rd = pop_d;
    assign txd          = txd_q;
    assign busy         = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_left_q <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else if (pop_d) begin
            // Pop from IDLE or from the last clock of the final stop bit:
            // latch the byte and the whole line configuration so later input
            // changes cannot disturb this frame.
            state_q     <= START;
            shift_q     <= fifo.fifo_data;
            div_q       <= divisor;
            cnt_q       <= divisor;
            bit_idx_q   <= '0;
            par_en_q    <= parity_en;
            par_bit_q   <= (^fifo.fifo_data) ^ parity_odd;
            stop2_q     <= stop2;
            stop_left_q <= 1'b0;
            txd_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                end

                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        cnt_q     <= div_q;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt_q <= div_q;
                        if (bit_idx_q == 3'd7) begin
                            if (par_en_q) begin
                                state_q <= PARITY;
                                txd_q   <= par_bit_q;
                            end else begin
                                state_q     <= STOP;
                                txd_q       <= 1'b1;
                                stop_left_q <= stop2_q;
                            end
                        end else begin
                            // txd shows shift_q[0]; the next bit sits at [1].
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        state_q     <= STOP;
                        cnt_q       <= div_q;
                        txd_q       <= 1'b1;
                        stop_left_q <= stop2_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        if (stop_left_q) begin
                            stop_left_q <= 1'b0;
                            cnt_q       <= div_q;
                        end else begin
                            // Back-to-back continuation is taken by the pop
                            // branch above; reaching here means no new frame.
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upuart_tx.sv
// Directed testbench for upuart_tx: hand-computed line waveforms per frame.
// Latency: checks start bit the cycle after each observed pop.
// Backpressure: a queue models the show-ahead TX FIFO, popped on each fifo_rd.
module tb_upuart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] divisor;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        txd;
    logic        busy;

    always #5 clk = ~clk;

    upuart_tx_if fif ();

    upuart_tx #(.DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .divisor    (divisor),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .fifo       (fif),
        .txd        (txd),
        .busy       (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    int   pop_cnt = 0;
    int   bad_rd  = 0;
    logic rd_seen = 1'b0;

    logic txd_tr  [0:63];
    logic busy_tr [0:63];
    logic rd_tr   [0:63];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void fifo_refresh();
        fif.fifo_empty = (q.size() == 0);
        fif.fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_refresh();
    endtask

    // FIFO model: the strobe is sampled mid-cycle, the head is removed just
    // after the edge that the DUT uses to capture it.
    always @(negedge clk) begin
        rd_seen = fif.fifo_rd;
        if (rd_seen) begin
            pop_cnt++;
            if (fif.fifo_empty) bad_rd++;
        end
    end

    always @(posedge clk) begin
        if (rd_seen) begin
            #1;
            if (q.size() != 0) q.delete(0);
            fifo_refresh();
        end
    end

    task automatic wait_rd(input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (fif.fifo_rd) hit = 1'b1;
        end
        check_eq({tag, "_rd_seen"}, 32'(hit), 32'd1);
    endtask

    task automatic capture(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            txd_tr[j]  = txd;
            busy_tr[j] = busy;
            rd_tr[j]   = fif.fifo_rd;
        end
    endtask

    function automatic int busy_count(input int n);
        int s = 0;
        for (int j = 0; j < n; j++) s += int'(busy_tr[j]);
        return s;
    endfunction

    function automatic int rd_count(input int n);
        int s = 0;
        for (int j = 0; j < n; j++) s += int'(rd_tr[j]);
        return s;
    endfunction

    // exp holds the line bits in transmit order, bit 0 = start bit.
    task automatic check_frame(input string tag, input int off, input int nbits,
                               input logic [15:0] exp, input int div);
        logic [31:0] word;
        logic [31:0] mask;
        mask = (32'd1 << (div + 1)) - 32'd1;
        for (int i = 0; i < nbits; i++) begin
            word = '0;
            for (int c = 0; c <= div; c++) word[c] = txd_tr[off + i * (div + 1) + c];
            check_eq($sformatf("%s_bit%0d", tag, i), word, exp[i] ? mask : 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int t;
        int b;

        rst        = 1'b1;
        enable     = 1'b1;
        divisor    = 16'd3;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        fifo_refresh();
        push(8'h55);

        // Reset state, with data waiting and enable high: no pop under reset.
        repeat (3) @(negedge clk);
        check_eq("rst_txd",  32'(txd), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd",   32'(fif.fifo_rd), 32'd0);
        check_eq("rst_pops", pop_cnt, 0);

        // 0x55, divisor 3, 8N1; config changes during START must be ignored.
        @(posedge clk); #2;
        rst = 1'b0;
        wait_rd("t1");
        fork
            capture(44);
            begin
                @(posedge clk); #2;
                divisor   = 16'd0;
                parity_en = 1'b1;
                stop2     = 1'b1;
            end
        join
        check_frame("t1", 0, 10, 16'b0000_0010_1010_1010, 3);
        check_eq("t1_busy_len", busy_count(44), 40);
        check_eq("t1_idle_busy", 32'(busy_tr[40]), 32'd0);
        check_eq("t1_extra_rd", rd_count(44), 0);
        check_eq("t1_idle_txd", {28'd0, txd_tr[40], txd_tr[41], txd_tr[42], txd_tr[43]}, 32'hF);

        // 0x07, divisor 0, even parity, two stop bits.
        @(posedge clk); #2;
        divisor    = 16'd0;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        stop2      = 1'b1;
        push(8'h07);
        wait_rd("t2");
        capture(16);
        check_frame("t2", 0, 12, 16'h0E0E, 0);
        check_eq("t2_busy_len", busy_count(16), 12);
        check_eq("t2_idle_busy", 32'(busy_tr[12]), 32'd0);

        // 0xA3 then 0x3C back-to-back, divisor 1, 8N1.
        @(posedge clk); #2;
        divisor   = 16'd1;
        parity_en = 1'b0;
        stop2     = 1'b0;
        push(8'hA3);
        push(8'h3C);
        wait_rd("t3");
        capture(44);
        check_frame("t3a", 0, 10, 16'b0000_0011_0100_0110, 1);
        check_frame("t3b", 20, 10, 16'b0000_0010_0111_1000, 1);
        check_eq("t3_rd_at_19", 32'(rd_tr[19]), 32'd1);
        check_eq("t3_rd_count", rd_count(44), 1);
        check_eq("t3_busy_len", busy_count(44), 40);
        check_eq("t3_idle_busy", 32'(busy_tr[40]), 32'd0);

        // Empty FIFO with enable high: line stays idle.
        r = 0; t = 0; b = 0;
        repeat (100) begin
            @(negedge clk);
            r += int'(fif.fifo_rd);
            t += int'(!txd);
            b += int'(busy);
        end
        check_eq("t4_rd", r, 0);
        check_eq("t4_txd_low", t, 0);
        check_eq("t4_busy", b, 0);

        // Reset during data bit 4 of 0xFF, divisor 3.
        @(posedge clk); #2;
        divisor = 16'd3;
        push(8'hFF);
        wait_rd("t5");
        capture(21);
        @(posedge clk); #2;
        rst = 1'b1;
        push(8'h12);
        @(negedge clk);
        check_eq("t5_busy_pre", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("t5_txd_post", 32'(txd), 32'd1);
        check_eq("t5_busy_post", 32'(busy), 32'd0);
        r = 0;
        repeat (3) begin
            @(negedge clk);
            r += int'(fif.fifo_rd);
        end
        check_eq("t5_rd_in_rst", r, 0);
        @(posedge clk); #2;
        rst    = 1'b0;
        enable = 1'b0;
        r = 0; b = 0;
        repeat (10) begin
            @(negedge clk);
            r += int'(fif.fifo_rd);
            b += int'(busy);
        end
        check_eq("t5_rd_disabled", r, 0);
        check_eq("t5_busy_disabled", b, 0);
        @(posedge clk); #2;
        enable = 1'b1;
        wait_rd("t5b");
        capture(44);
        check_frame("t5b", 0, 10, 16'b0000_0010_0010_0100, 3);
        check_eq("t5b_busy_len", busy_count(44), 40);

        // Enable dropped during START of 0x81 with 0x42 queued, divisor 1.
        @(posedge clk); #2;
        divisor = 16'd1;
        push(8'h81);
        push(8'h42);
        wait_rd("t6");
        fork
            capture(30);
            begin
                @(posedge clk); #2;
                enable = 1'b0;
            end
        join
        check_frame("t6a", 0, 10, 16'b0000_0011_0000_0010, 1);
        check_eq("t6_rd_count", rd_count(30), 0);
        check_eq("t6_busy_len", busy_count(30), 20);
        r = 0;
        repeat (20) begin
            @(negedge clk);
            r += int'(fif.fifo_rd);
        end
        check_eq("t6_rd_disabled", r, 0);
        @(posedge clk); #2;
        enable = 1'b1;
        wait_rd("t6b");
        capture(24);
        check_frame("t6b", 0, 10, 16'b0000_0010_1000_0100, 1);

        repeat (4) @(negedge clk);
        check_eq("total_pops", pop_cnt, 8);
        check_eq("rd_while_empty", bad_rd, 0);
        check_eq("fifo_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/upuart_tx.md
UPUART_TX -- requirements
Module: upuart_tx

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, the width of the baud divisor.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 SHALL have port enable, input, 1, which permits starting new frames.
REQ-005 SHALL have port divisor, input, DIV_WIDTH, where bit period = divisor+1 clocks.
REQ-006 SHALL have port parity_en, input, 1, which inserts a parity bit after the data bits.
REQ-007 SHALL have port parity_odd, input, 1, where 1 = odd parity and 0 = even parity.
REQ-008 SHALL have port stop2, input, 1, where 1 = two stop bits and 0 = one stop bit.
REQ-009 SHALL have port fifo_data, input, 8, the TX FIFO head word (show-ahead, valid when not empty).
REQ-010 SHALL have port fifo_empty, input, 1, the TX FIFO empty flag.
REQ-011 SHALL have port fifo_rd, output, 1, a one-cycle pop strobe to the TX FIFO.
REQ-012 SHALL have port txd, output, 1, the serial line, idle high.
REQ-013 SHALL have port busy, output, 1, high while a frame is on the line.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL assert fifo_rd in IDLE for exactly one cycle when enable=1 and fifo_empty=0, then move to START on the next cycle.
REQ-016 SHALL capture fifo_data, divisor, parity_en, parity_odd and stop2 in the fifo_rd cycle; input changes mid-frame SHALL NOT affect the current frame.
REQ-017 SHALL drive txd=0 in START, which begins the cycle after fifo_rd.
REQ-018 SHALL send 8 data bits LSB first in DATA.
REQ-019 SHALL send in PARITY (only when parity_en is latched) the XOR of the data bits, inverted when parity_odd is latched.
REQ-020 SHALL drive txd=1 in STOP for 1 bit period, or 2 bit periods when stop2 is latched.
REQ-021 SHALL hold every bit for exactly divisor+1 clocks using a down-counter reloaded at each bit boundary; divisor=0 SHALL give 1 clock per bit.
REQ-022 SHALL use a 3-bit bit index in DATA that advances on bit boundaries and leaves DATA after index 7 completes.
REQ-023 SHALL, in the last clock of the final stop bit with enable=1 and fifo_empty=0, assert fifo_rd and go directly to START so that frames run back-to-back with no idle cycle.
REQ-024 SHALL otherwise return from the final stop bit to IDLE with txd=1.
REQ-025 SHALL hold busy=1 in START, DATA, PARITY and STOP, and busy=0 in IDLE.
REQ-026 SHALL complete any frame in progress when enable deasserts; enable gates only new pops.
REQ-027 SHALL never assert fifo_rd while fifo_empty=1 and never assert it outside IDLE or the last stop-bit clock.
REQ-028 SHALL produce a frame of 10, 11 or 12 bit periods, i.e. (1+8+parity_en+1+stop2) x (divisor+1) clocks, measured from the cycle after fifo_rd.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, force state=IDLE, txd=1, busy=0, fifo_rd=0, and clear the counters and shift register.
REQ-030 SHALL abort a frame in progress when rst is asserted, with txd=1 from the next edge and no pop issued during rst.
REQ-031 SHALL pop the FIFO no earlier than the first edge with rst=0.

Verification
REQ-032 SHALL cover: divisor=3, no parity, 1 stop, FIFO holds 0x55 -> one fifo_rd; txd = 0,1,0,1,0,1,0,1,0,1 with each bit lasting 4 clocks; 40 clocks busy; then IDLE.
REQ-033 SHALL cover: divisor=0, parity_en=1, parity_odd=0, stop2=1, byte 0x07 -> bits 0,1,1,1,0,0,0,0,0,1(parity),1,1; busy lasts 12 clocks.
REQ-034 SHALL cover: divisor=1, FIFO holds 0xA3 then 0x3C -> fifo_rd pulses 20 clocks apart; second start bit immediately follows the first stop bit; busy stays high for 40 clocks.
REQ-035 SHALL cover: enable=1 with fifo_empty=1 for 100 clocks -> fifo_rd=0, txd=1, busy=0 throughout.
REQ-036 SHALL cover: rst=1 during DATA bit 4 of 0xFF -> txd=1 and busy=0 the next cycle; after release, no pop until enable=1 with fifo_empty=0.
REQ-037 SHALL cover: enable dropped during START of 0x81 with more data queued -> the full 0x81 frame completes; no further fifo_rd occurs until enable returns.
